// File: rtl/gpio_fun_ctrl.sv
// rtl/gpio_fun_ctrl.sv - GPIO pad function-select controller with break-before-make sequencing and input-change irq; optional lock via GPIO_FUN_LOCK_EN
module gpio_fun_ctrl #(
    parameter int NPINS = 8,
    parameter int GUARD = 2,
    parameter int PW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PW-1:0]      wr_pin,
    input  logic [1:0]         wr_fun,
    output logic               wr_ready,
    output logic [2*NPINS-1:0] fun_out,
    output logic               busy,
    input  logic [NPINS-1:0]   pin_in,
    output logic [NPINS-1:0]   pin_sync,
    input  logic [NPINS-1:0]   irq_clr,
    output logic [NPINS-1:0]   irq_stat,
    output logic               irq
`ifdef GPIO_FUN_LOCK_EN
    ,
    input  logic               lock,
    output logic               lock_err
`endif
);

    // ISOLATE covers GUARD-1 of the guard cycles; APPLY is the final guard cycle.
    localparam int CW   = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int LAST = (GUARD > 1) ? GUARD - 2 : 0;

    typedef enum logic [1:0] {IDLE, ISOLATE, APPLY} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    lat_pin;
    logic [1:0]       lat_fun;
    logic [1:0]       fun_q [NPINS];
    logic [1:0]       cur_fun;
    logic [NPINS-1:0] sync1, prev, mode0;
    logic             pin_ok, accept, take, direct, start_seq;

    always_comb begin
        cur_fun = 2'd3;
        for (int i = 0; i < NPINS; i++)
            if (wr_pin == PW'(i)) cur_fun = fun_q[i];
    end

    assign pin_ok    = int'(wr_pin) < NPINS;
    assign accept    = wr_en & wr_ready & pin_ok;
`ifdef GPIO_FUN_LOCK_EN
    assign take      = accept & ~lock;
`else
    assign take      = accept;
`endif
    assign direct    = (wr_fun == cur_fun) || (wr_fun == 2'd3);
    assign start_seq = take & ~direct;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_seq) state_n = (GUARD > 1) ? ISOLATE : APPLY;
            ISOLATE: if (cnt == CW'(LAST)) state_n = APPLY;
            APPLY:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        wr_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPINS; i++) fun_q[i] <= 2'd3;
            cnt     <= '0;
            lat_pin <= '0;
            lat_fun <= 2'd0;
        end else begin
            if (take) begin
                for (int i = 0; i < NPINS; i++)
                    if (wr_pin == PW'(i)) fun_q[i] <= direct ? wr_fun : 2'd3;
                lat_pin <= wr_pin;
                lat_fun <= wr_fun;
                cnt     <= '0;
            end
            if (state == ISOLATE) cnt <= cnt + CW'(1);
            if (state == APPLY)
                for (int i = 0; i < NPINS; i++)
                    if (lat_pin == PW'(i)) fun_q[i] <= lat_fun;
        end
    end

    always_comb begin
        fun_out = '0;
        mode0   = '0;
        for (int i = 0; i < NPINS; i++) begin
            fun_out[2*i +: 2] = fun_q[i];
            mode0[i]          = (fun_q[i] == 2'd0);
        end
    end

    // Set is OR-ed after the clear mask so a same-edge set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            pin_sync <= '0;
            prev     <= '0;
            irq_stat <= '0;
        end else begin
            sync1    <= pin_in;
            pin_sync <= sync1;
            prev     <= pin_sync;
            irq_stat <= (irq_stat & ~irq_clr) | ((pin_sync ^ prev) & mode0);
        end
    end

    assign irq = |irq_stat;

`ifdef GPIO_FUN_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) lock_err <= 1'b0;
        else     lock_err <= accept & lock;
    end
`endif

endmodule
